blake2_msg_feeder: RTL and testbench

- Upstream framer for the BLAKE2s compression core.
- Turns a host byte stream (valid/ready, last flag) into the core's 64-byte block interface: `data_v`, `data_idx`, `data`, `block_first`, `block_last`, `ll`.
- Handles key-block insertion and zero padding of the key block and of the final message block.
- Counts total length `ll`, and holds off a new job until the core has finished streaming the hash.

---
 rtl/blake2_msg_feeder_if.sv | 22 ++
 rtl/blake2_msg_feeder.sv | 183 ++++++++++++++++++
 tb/tb_blake2_msg_feeder.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/blake2_msg_feeder_if.sv
// Host byte stream into the BLAKE2s message feeder: valid/ready handshake,
// one byte per beat, with a last-byte marker closing the message.
interface blake2_msg_feeder_if;
  logic       s_valid;
  logic       s_last;
  logic [7:0] s_data;
  logic       s_ready;

  modport master (
    output s_valid,
    output s_last,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_last,
    input  s_data,
    output s_ready
  );
endinterface

// File: rtl/blake2_msg_feeder.sv
// BLAKE2s message feeder: frames a host byte stream into 64-byte core blocks,
// inserting the zero-padded key block, zero-padding the final message block,
// counting the total length and holding off new jobs until the hash is out.
module blake2_msg_feeder #(
  parameter int BLK    = 64,
  parameter int LL_W   = 64,
  parameter int KN_W   = 6,
  parameter int NN_MAX = 32
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic                    start_i,
  input  logic [KN_W-1:0]         kk_i,
  input  logic [KN_W-1:0]         nn_i,
  input  logic                    empty_i,
  output logic                    busy_o,
  output logic                    cfg_err_o,
  blake2_msg_feeder_if.slave      host,
  input  logic                    core_ready_i,
  input  logic                    core_h_v_i,
  output logic                    data_v_o,
  output logic [$clog2(BLK)-1:0]  data_idx_o,
  output logic [7:0]              data_o,
  output logic                    block_first_o,
  output logic                    block_last_o,
  output logic [LL_W-1:0]         ll_o,
  output logic [KN_W-1:0]         kk_o,
  output logic [KN_W-1:0]         nn_o
);

  localparam int IDX_W = $clog2(BLK);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BLK - 1);
  localparam logic [KN_W-1:0]  KN_MAX   = KN_W'(NN_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_KEY, S_KEY_PAD, S_MSG, S_PAD, S_WAIT_H, S_WAIT_HL
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [LL_W-1:0]   ll_q, ll_d;
  logic [KN_W-1:0]   kk_q, kk_d, nn_q, nn_d;
  logic              empty_q, empty_d;
  logic              first_q, first_d;
  logic              last_q, last_d;
  logic              cfg_err_q, cfg_err_d;

  logic              s_ready;
  logic              blk_end;
  logic              cfg_bad;
  logic              streaming;
  logic [IDX_W-1:0]  key_last_idx;

  assign blk_end      = (idx_q == IDX_LAST);
  assign key_last_idx = IDX_W'(kk_q) - IDX_W'(1);
  assign cfg_bad      = (kk_i > KN_MAX) || (nn_i == '0) || (nn_i > KN_MAX);
  assign streaming    = (state_q == S_KEY) || (state_q == S_KEY_PAD) ||
                        (state_q == S_MSG) || (state_q == S_PAD);

  // Byte path to the core: passthrough in KEY/MSG, zero fill in the pad states;
  // a strobe is only ever raised while the core is ready, since it shifts on each.
  always_comb begin
    s_ready  = 1'b0;
    data_v_o = 1'b0;
    data_o   = '0;
    case (state_q)
      S_KEY, S_MSG: begin
        s_ready  = core_ready_i;
        data_v_o = host.s_valid & core_ready_i;
        data_o   = host.s_data;
      end
      S_KEY_PAD, S_PAD: begin
        data_v_o = core_ready_i;
      end
      default: ;
    endcase
  end

  assign host.s_ready  = s_ready;
  assign data_idx_o    = idx_q;
  assign busy_o        = (state_q != S_IDLE);
  assign cfg_err_o     = cfg_err_q;
  assign block_first_o = first_q;
  // The last flag must already be high on the strobe carrying the last byte.
  assign block_last_o  = streaming &
                         (last_q | ((state_q == S_MSG) & host.s_valid & host.s_last));
  assign ll_o          = ll_q;
  assign kk_o          = kk_q;
  assign nn_o          = nn_q;

  // Next-state: job sequencing, byte index/length counting and block flags.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ll_d      = ll_q;
    kk_d      = kk_q;
    nn_d      = nn_q;
    empty_d   = empty_q;
    first_d   = first_q;
    last_d    = last_q;
    cfg_err_d = 1'b0;

    if (data_v_o) begin
      idx_d = idx_q + IDX_W'(1);
      if (blk_end) first_d = 1'b0;
      // Padding of the final block is not part of the message length.
      if (state_q != S_PAD) ll_d = ll_q + LL_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            kk_d    = kk_i;
            nn_d    = nn_i;
            empty_d = empty_i;
            idx_d   = '0;
            ll_d    = '0;
            first_d = 1'b1;
            // With no message, the first block (key or pad-only) is also the last.
            last_d  = empty_i;
            if (kk_i != '0)   state_d = S_KEY;
            else if (empty_i) state_d = S_PAD;
            else              state_d = S_MSG;
          end
        end
      end
      S_KEY: begin
        if (data_v_o && (idx_q == key_last_idx)) begin
          if (blk_end) state_d = empty_q ? S_WAIT_H : S_MSG;
          else         state_d = S_KEY_PAD;
        end
      end
      S_KEY_PAD: begin
        if (data_v_o && blk_end) state_d = empty_q ? S_WAIT_H : S_MSG;
      end
      S_MSG: begin
        if (data_v_o && host.s_last) begin
          last_d  = 1'b1;
          state_d = blk_end ? S_WAIT_H : S_PAD;
        end
      end
      S_PAD: begin
        if (data_v_o && blk_end) state_d = S_WAIT_H;
      end
      S_WAIT_H: begin
        if (core_h_v_i) state_d = S_WAIT_HL;
      end
      S_WAIT_HL: begin
        if (!core_h_v_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and counters; reset abandons any job in flight.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      ll_q      <= '0;
      kk_q      <= '0;
      nn_q      <= '0;
      empty_q   <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ll_q      <= ll_d;
      kk_q      <= kk_d;
      nn_q      <= nn_d;
      empty_q   <= empty_d;
      first_q   <= first_d;
      last_q    <= last_d;
      cfg_err_q <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_blake2_msg_feeder.sv
// Directed bench for blake2_msg_feeder: drives jobs from a host byte source,
// plays the core side (ready, stall, h_v pulse) and checks every strobe.
module tb_blake2_msg_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nreset, start_i, empty_i, core_ready_i, core_h_v_i;
  logic [5:0]  kk_i, nn_i;
  logic        busy_o, cfg_err_o, data_v_o, block_first_o, block_last_o;
  logic [5:0]  data_idx_o, kk_o, nn_o;
  logic [7:0]  data_o;
  logic [63:0] ll_o;

  blake2_msg_feeder_if hif();

  blake2_msg_feeder dut (
    .clk           (clk),
    .nreset        (nreset),
    .start_i       (start_i),
    .kk_i          (kk_i),
    .nn_i          (nn_i),
    .empty_i       (empty_i),
    .busy_o        (busy_o),
    .cfg_err_o     (cfg_err_o),
    .host          (hif),
    .core_ready_i  (core_ready_i),
    .core_h_v_i    (core_h_v_i),
    .data_v_o      (data_v_o),
    .data_idx_o    (data_idx_o),
    .data_o        (data_o),
    .block_first_o (block_first_o),
    .block_last_o  (block_last_o),
    .ll_o          (ll_o),
    .kk_o          (kk_o),
    .nn_o          (nn_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] src[$];
  logic       src_last;

  logic [5:0] cap_idx  [256];
  logic [7:0] cap_data [256];
  logic       cap_first[256];
  logic       cap_last [256];
  int         cap_n;

  logic        sready_seen, cfg_seen, done, aborted;
  int          stall_bad, stall_cycles;
  logic [63:0] ll_hv, ll_end;
  logic        busy_wait, busy_hv, went_idle, busy_late;
  logic [5:0]  kk_end, nn_end;

  task automatic do_reset();
    nreset       = 1'b0;
    start_i      = 1'b0;
    kk_i         = '0;
    nn_i         = '0;
    empty_i      = 1'b0;
    core_ready_i = 1'b1;
    core_h_v_i   = 1'b0;
    hif.s_valid  = 1'b0;
    hif.s_last   = 1'b0;
    hif.s_data   = '0;
    repeat (2) @(posedge clk);
    #1 nreset = 1'b1;
    @(posedge clk); #1;
  endtask

  // Runs one job: start pulse, byte source, core ready/stall, then the h_v
  // handshake (with an extra start pulse during WAIT_H that must be ignored).
  task automatic run_job(input logic [5:0] kk, input logic [5:0] nn,
                         input logic empty, input int stall, input int abort_at);
    int   ptr;
    int   stall_left;
    logic stall_used;
    cap_n = 0; sready_seen = 0; cfg_seen = 0; stall_bad = 0; stall_cycles = 0;
    done = 0; aborted = 0; ptr = 0; stall_left = 0; stall_used = 0;
    ll_hv = '1; ll_end = '1; busy_wait = 0; busy_hv = 0; went_idle = 0;
    busy_late = 1; kk_end = '1; nn_end = '1;
    kk_i = kk; nn_i = nn; empty_i = empty; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (ptr < src.size()) begin
        hif.s_valid = 1'b1;
        hif.s_data  = src[ptr];
        hif.s_last  = src_last && (ptr == src.size() - 1);
      end else begin
        hif.s_valid = 1'b0;
        hif.s_data  = 8'h00;
        hif.s_last  = 1'b0;
      end
      core_ready_i = (stall_left == 0);
      @(negedge clk);
      if (hif.s_ready) sready_seen = 1;
      if (cfg_err_o) cfg_seen = 1;
      if (!core_ready_i) begin
        stall_cycles++;
        stall_left--;
        if (data_v_o || hif.s_ready) stall_bad++;
      end
      if (hif.s_valid && hif.s_ready) ptr++;
      if (data_v_o) begin
        if (cap_n < 256) begin
          cap_idx[cap_n]   = data_idx_o;
          cap_data[cap_n]  = data_o;
          cap_first[cap_n] = block_first_o;
          cap_last[cap_n]  = block_last_o;
        end
        cap_n++;
        if (block_last_o && data_idx_o == 6'd63) done = 1;
        if (stall > 0 && !stall_used && data_idx_o == 6'd63) begin
          stall_left = stall;
          stall_used = 1;
        end
      end
      @(posedge clk); #1;
      if (done) break;
      if (abort_at >= 0 && cap_n >= abort_at) begin
        aborted = 1;
        break;
      end
    end
    if (done) begin
      hif.s_valid = 1'b0;
      hif.s_last  = 1'b0;
      hif.s_data  = '0;
      start_i = 1'b1; kk_i = 6'd5; nn_i = 6'd7; empty_i = 1'b0;
      @(negedge clk); busy_wait = busy_o;
      @(posedge clk); #1; start_i = 1'b0;
      @(posedge clk); #1; core_h_v_i = 1'b1;
      @(negedge clk); ll_hv = ll_o; busy_hv = busy_o;
      repeat (3) begin @(posedge clk); #1; end
      core_h_v_i = 1'b0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (!busy_o) begin
          went_idle = 1;
          break;
        end
        @(posedge clk); #1;
      end
      ll_end = ll_o; kk_end = kk_o; nn_end = nn_o;
      repeat (2) begin @(posedge clk); #1; end
      busy_late = busy_o;
    end
  endtask

  task automatic test_reset();
    nreset = 1'b0; start_i = 1'b0; kk_i = 6'd4; nn_i = 6'd32; empty_i = 1'b0;
    core_ready_i = 1'b1; core_h_v_i = 1'b0;
    hif.s_valid = 1'b1; hif.s_last = 1'b0; hif.s_data = 8'hA5;
    #1;
    n_checks++;
    if ({busy_o, cfg_err_o, hif.s_ready, data_v_o, block_first_o, block_last_o} !== 6'b0)
      $display("FAIL reset_ctrl: got %b want 000000",
               {busy_o, cfg_err_o, hif.s_ready, data_v_o, block_first_o, block_last_o});
    else n_pass++;
    n_checks++;
    if ({data_idx_o, data_o, kk_o, nn_o, ll_o} !== '0)
      $display("FAIL reset_data: idx=%0d data=%0h kk=%0d nn=%0d ll=%0d want all 0",
               data_idx_o, data_o, kk_o, nn_o, ll_o);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1 nreset = 1'b1;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if ({busy_o, hif.s_ready, data_v_o} !== 3'b0)
      $display("FAIL idle_after_reset: busy/s_ready/data_v got %b want 000",
               {busy_o, hif.s_ready, data_v_o});
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_abc();
    do_reset();
    src = '{8'h61, 8'h62, 8'h63};
    src_last = 1'b1;
    run_job(6'd0, 6'd32, 1'b0, 0, -1);
    n_checks++;
    if (done !== 1'b1) $display("FAIL abc_done: final strobe seen=%b want 1", done);
    else n_pass++;
    n_checks++;
    if (cap_n !== 64) $display("FAIL abc_count: got %0d want 64", cap_n);
    else n_pass++;
    for (int i = 0; i < 64; i++) begin
      logic [7:0] ed;
      ed = (i < 3) ? 8'(8'h61 + i) : 8'h00;
      if (i < cap_n) begin
        n_checks++;
        if ({cap_idx[i], cap_data[i], cap_first[i], cap_last[i]} !== {6'(i), ed, 1'b1, (i >= 2)})
          $display("FAIL abc_strobe%0d: idx=%0d data=%0h first=%b last=%b want idx=%0d data=%0h first=1 last=%b",
                   i, cap_idx[i], cap_data[i], cap_first[i], cap_last[i], i, ed, (i >= 2));
        else n_pass++;
      end
    end
    n_checks++;
    if (ll_hv !== 64'd3) $display("FAIL abc_ll: got %0d want 3", ll_hv);
    else n_pass++;
    n_checks++;
    if ({busy_wait, busy_hv, went_idle, busy_late} !== 4'b1110)
      $display("FAIL abc_busy: wait/hv/idle/late got %b want 1110",
               {busy_wait, busy_hv, went_idle, busy_late});
    else n_pass++;
    n_checks++;
    if ({kk_end, nn_end, ll_end} !== {6'd0, 6'd32, 64'd3})
      $display("FAIL abc_held: kk=%0d nn=%0d ll=%0d want kk=0 nn=32 ll=3", kk_end, nn_end, ll_end);
    else n_pass++;
  endtask

  task automatic test_empty();
    do_reset();
    src.delete();
    src_last = 1'b0;
    run_job(6'd0, 6'd32, 1'b1, 0, -1);
    n_checks++;
    if (cap_n !== 64) $display("FAIL empty_count: got %0d want 64", cap_n);
    else n_pass++;
    for (int i = 0; i < 64; i++) begin
      if (i < cap_n) begin
        n_checks++;
        if ({cap_idx[i], cap_data[i], cap_first[i], cap_last[i]} !== {6'(i), 8'h00, 1'b1, 1'b1})
          $display("FAIL empty_strobe%0d: idx=%0d data=%0h first=%b last=%b want idx=%0d data=0 first=1 last=1",
                   i, cap_idx[i], cap_data[i], cap_first[i], cap_last[i], i);
        else n_pass++;
      end
    end
    n_checks++;
    if (ll_hv !== 64'd0) $display("FAIL empty_ll: got %0d want 0", ll_hv);
    else n_pass++;
    n_checks++;
    if (sready_seen !== 1'b0) $display("FAIL empty_sready: s_ready seen=%b want 0", sready_seen);
    else n_pass++;
    n_checks++;
    if (went_idle !== 1'b1) $display("FAIL empty_idle: got %b want 1", went_idle);
    else n_pass++;
  endtask

  task automatic test_keyed_empty();
    do_reset();
    src.delete();
    for (int i = 0; i < 32; i++) src.push_back(8'(8'h80 + i));
    src_last = 1'b0;
    run_job(6'd32, 6'd32, 1'b1, 0, -1);
    n_checks++;
    if (cap_n !== 64) $display("FAIL kempty_count: got %0d want 64", cap_n);
    else n_pass++;
    for (int i = 0; i < 64; i++) begin
      logic [7:0] ed;
      ed = (i < 32) ? 8'(8'h80 + i) : 8'h00;
      if (i < cap_n) begin
        n_checks++;
        if ({cap_idx[i], cap_data[i], cap_first[i], cap_last[i]} !== {6'(i), ed, 1'b1, 1'b1})
          $display("FAIL kempty_strobe%0d: idx=%0d data=%0h first=%b last=%b want idx=%0d data=%0h first=1 last=1",
                   i, cap_idx[i], cap_data[i], cap_first[i], cap_last[i], i, ed);
        else n_pass++;
      end
    end
    n_checks++;
    if (ll_hv !== 64'd64) $display("FAIL kempty_ll: got %0d want 64", ll_hv);
    else n_pass++;
    n_checks++;
    if (cfg_seen !== 1'b0) $display("FAIL kempty_cfgerr: kk=32 start flagged=%b want 0", cfg_seen);
    else n_pass++;
    n_checks++;
    if (kk_end !== 6'd32) $display("FAIL kempty_kk: got %0d want 32", kk_end);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    src.delete();
    for (int j = 0; j < 128; j++) src.push_back(8'(j * 7 + 3));
    src_last = 1'b1;
    run_job(6'd0, 6'd32, 1'b0, 80, -1);
    n_checks++;
    if (cap_n !== 128) $display("FAIL b2b_count: got %0d want 128", cap_n);
    else n_pass++;
    for (int i = 0; i < 128; i++) begin
      if (i < cap_n) begin
        n_checks++;
        if ({cap_idx[i], cap_data[i], cap_first[i], cap_last[i]} !==
            {6'(i % 64), 8'(i * 7 + 3), (i < 64), (i == 127)})
          $display("FAIL b2b_strobe%0d: idx=%0d data=%0h first=%b last=%b want idx=%0d data=%0h first=%b last=%b",
                   i, cap_idx[i], cap_data[i], cap_first[i], cap_last[i],
                   i % 64, 8'(i * 7 + 3), (i < 64), (i == 127));
        else n_pass++;
      end
    end
    n_checks++;
    if (stall_cycles !== 80) $display("FAIL b2b_stall_len: got %0d want 80", stall_cycles);
    else n_pass++;
    n_checks++;
    if (stall_bad !== 0) $display("FAIL b2b_stall_quiet: active cycles %0d want 0", stall_bad);
    else n_pass++;
    n_checks++;
    if (ll_hv !== 64'd128) $display("FAIL b2b_ll: got %0d want 128", ll_hv);
    else n_pass++;
  endtask

  task automatic test_keyed_msg();
    do_reset();
    src.delete();
    for (int i = 0; i < 16; i++) src.push_back(8'(8'h80 + i));
    for (int j = 0; j < 65; j++) src.push_back(8'(j) ^ 8'hC5);
    src_last = 1'b1;
    run_job(6'd16, 6'd20, 1'b0, 0, -1);
    n_checks++;
    if (cap_n !== 192) $display("FAIL kmsg_count: got %0d want 192", cap_n);
    else n_pass++;
    for (int i = 0; i < 192; i++) begin
      logic [7:0] ed;
      if (i < 16)       ed = 8'(8'h80 + i);
      else if (i < 64)  ed = 8'h00;
      else if (i < 129) ed = 8'(i - 64) ^ 8'hC5;
      else              ed = 8'h00;
      if (i < cap_n) begin
        n_checks++;
        if ({cap_idx[i], cap_data[i], cap_first[i], cap_last[i]} !==
            {6'(i % 64), ed, (i < 64), (i >= 128)})
          $display("FAIL kmsg_strobe%0d: idx=%0d data=%0h first=%b last=%b want idx=%0d data=%0h first=%b last=%b",
                   i, cap_idx[i], cap_data[i], cap_first[i], cap_last[i],
                   i % 64, ed, (i < 64), (i >= 128));
        else n_pass++;
      end
    end
    n_checks++;
    if (ll_hv !== 64'd129) $display("FAIL kmsg_ll: got %0d want 129", ll_hv);
    else n_pass++;
    n_checks++;
    if ({kk_end, nn_end} !== {6'd16, 6'd20})
      $display("FAIL kmsg_knn: kk=%0d nn=%0d want kk=16 nn=20", kk_end, nn_end);
    else n_pass++;
  endtask

  task automatic test_cfg_err();
    do_reset();
    start_i = 1'b1; kk_i = 6'd33; nn_i = 6'd32; empty_i = 1'b0;
    @(posedge clk); #1; start_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({cfg_err_o, busy_o} !== 2'b10)
      $display("FAIL cfg_kk33: cfg_err/busy got %b want 10", {cfg_err_o, busy_o});
    else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ({cfg_err_o, busy_o} !== 2'b00)
      $display("FAIL cfg_pulse_end: cfg_err/busy got %b want 00", {cfg_err_o, busy_o});
    else n_pass++;
    @(posedge clk); #1;
    start_i = 1'b1; kk_i = 6'd0; nn_i = 6'd0;
    @(posedge clk); #1; start_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({cfg_err_o, busy_o} !== 2'b10)
      $display("FAIL cfg_nn0: cfg_err/busy got %b want 10", {cfg_err_o, busy_o});
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    do_reset();
    src.delete();
    for (int j = 0; j < 128; j++) src.push_back(8'(j + 16));
    src_last = 1'b1;
    run_job(6'd0, 6'd32, 1'b0, 0, 10);
    n_checks++;
    if ({aborted, data_idx_o, data_v_o, busy_o} !== {1'b1, 6'd10, 1'b1, 1'b1})
      $display("FAIL midrst_pre: aborted=%b idx=%0d data_v=%b busy=%b want 1 10 1 1",
               aborted, data_idx_o, data_v_o, busy_o);
    else n_pass++;
    nreset = 1'b0;
    #1;
    n_checks++;
    if ({busy_o, cfg_err_o, hif.s_ready, data_v_o, block_first_o, block_last_o} !== 6'b0)
      $display("FAIL midrst_ctrl: got %b want 000000",
               {busy_o, cfg_err_o, hif.s_ready, data_v_o, block_first_o, block_last_o});
    else n_pass++;
    n_checks++;
    if ({data_idx_o, data_o, kk_o, nn_o, ll_o} !== '0)
      $display("FAIL midrst_data: idx=%0d data=%0h kk=%0d nn=%0d ll=%0d want all 0",
               data_idx_o, data_o, kk_o, nn_o, ll_o);
    else n_pass++;
    @(posedge clk); #1;
    nreset = 1'b1;
    @(posedge clk); #1;
    src = '{8'h61, 8'h62, 8'h63};
    src_last = 1'b1;
    run_job(6'd0, 6'd32, 1'b0, 0, -1);
    n_checks++;
    if (cap_n !== 64) $display("FAIL midrst_restart_count: got %0d want 64", cap_n);
    else n_pass++;
    n_checks++;
    if ({cap_idx[0], cap_data[0], cap_first[0]} !== {6'd0, 8'h61, 1'b1})
      $display("FAIL midrst_restart_first: idx=%0d data=%0h first=%b want idx=0 data=61 first=1",
               cap_idx[0], cap_data[0], cap_first[0]);
    else n_pass++;
    n_checks++;
    if (ll_hv !== 64'd3) $display("FAIL midrst_restart_ll: got %0d want 3", ll_hv);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_abc();
    test_empty();
    test_keyed_empty();
    test_back_to_back();
    test_keyed_msg();
    test_cfg_err();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
